// File: rtl/issue_rr_select_pkg.sv
// Shared types and defaults for the round-robin issue-port select controller.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package issue_rr_select_pkg;

  localparam int REQ_WIDTH_DEF     = 32;
  localparam int REQ_WIDTH_LOG_DEF = 5;

  // Grant index / priority pointer for the default configuration.
  typedef logic [REQ_WIDTH_LOG_DEF-1:0] grant_idx_t;

  typedef enum logic {
    SEL_IDLE = 1'b0,
    SEL_HOLD = 1'b1
  } sel_state_t;

endpackage

// File: rtl/issue_rr_select_encoder.sv
// One-hot to binary encoder for the next-grant vector.
// Latency: combinational.
// Backpressure: none; an all-zero input encodes to index 0.
//
// Ports:
//   onehot_i  ENCODER_WIDTH      one-hot (or zero) vector
//   idx_o     ENCODER_WIDTH_LOG  binary index of the set bit
module issue_rr_select_encoder #(
  parameter int ENCODER_WIDTH     = 32,
  parameter int ENCODER_WIDTH_LOG = 5
) (
  input  logic [ENCODER_WIDTH-1:0]     onehot_i,
  output logic [ENCODER_WIDTH_LOG-1:0] idx_o
);

  // OR-reduce the indices of the set bits; exact because the input is one-hot.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < ENCODER_WIDTH; i++) begin
      if (onehot_i[i]) begin
        idx_o = idx_o | ENCODER_WIDTH_LOG'(i);
      end
    end
  end

endmodule

// File: rtl/issue_rr_select.sv
// Round-robin select sharing one FU issue port among REQ_WIDTH requesters.
// Latency: grant_valid_o rises 1 cycle after req_i; back-to-back grants one per cycle.
// Backpressure: grant held stable until grant_ready_i; only flush_i retracts it.
//
// Ports:
//   clk, reset_n   clock, async active-low reset
//   flush_i        drop any held grant, pointer unchanged
//   req_i          per-entry ready-to-issue requests
//   grant_ready_i  FU port accepts the held grant
//   grant_valid_o  a grant is held
//   grant_vec_o    one-hot grant (zero when none)
//   grant_idx_o    binary index of grant_vec_o (zero when none)
//   ptr_o          current round-robin priority pointer
module issue_rr_select
  import issue_rr_select_pkg::*;
#(
  parameter int REQ_WIDTH     = REQ_WIDTH_DEF,
  parameter int REQ_WIDTH_LOG = REQ_WIDTH_LOG_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush_i,
  input  logic [REQ_WIDTH-1:0]     req_i,
  input  logic                     grant_ready_i,
  output logic                     grant_valid_o,
  output logic [REQ_WIDTH-1:0]     grant_vec_o,
  output logic [REQ_WIDTH_LOG-1:0] grant_idx_o,
  output logic [REQ_WIDTH_LOG-1:0] ptr_o
);

  typedef logic [REQ_WIDTH_LOG-1:0] idx_t;
  typedef logic [REQ_WIDTH-1:0]     vec_t;

  sel_state_t state_q, state_d;
  vec_t       grant_vec_q, grant_vec_d;
  idx_t       grant_idx_q, grant_idx_d;
  idx_t       ptr_q, ptr_d;

  logic handshake;
  idx_t ptr_adv;
  idx_t search_ptr;
  vec_t search_req;
  vec_t rot_req;
  vec_t rot_first;
  vec_t win_vec;
  idx_t win_idx;

  assign handshake = (state_q == SEL_HOLD) && grant_ready_i && !flush_i;
  assign ptr_adv   = (grant_idx_q == idx_t'(REQ_WIDTH - 1)) ? '0 : grant_idx_q + 1'b1;

  // On a handshake the next winner is searched from the advanced pointer, with
  // the accepted entry masked so a still-asserted req cannot win twice in a row.
  assign search_ptr = handshake ? ptr_adv : ptr_q;
  assign search_req = handshake ? (req_i & ~grant_vec_q) : req_i;

  // Rotate so search_ptr lands on bit 0. Explicit wrap keeps this correct for
  // non-power-of-two widths (pointer is always < REQ_WIDTH).
  always_comb begin
    rot_req = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      int j;
      j = i + int'(search_ptr);
      if (j >= REQ_WIDTH) j = j - REQ_WIDTH;
      rot_req[i] = search_req[j];
    end
  end

  // Fixed-priority find-first: isolate the lowest set bit.
  assign rot_first = rot_req & (~rot_req + 1'b1);

  // Rotate the isolated bit back to its original position.
  always_comb begin
    win_vec = '0;
    for (int i = 0; i < REQ_WIDTH; i++) begin
      int j;
      j = i + int'(search_ptr);
      if (j >= REQ_WIDTH) j = j - REQ_WIDTH;
      win_vec[j] = rot_first[i];
    end
  end

  issue_rr_select_encoder #(
    .ENCODER_WIDTH     (REQ_WIDTH),
    .ENCODER_WIDTH_LOG (REQ_WIDTH_LOG)
  ) u_encoder (
    .onehot_i (win_vec),
    .idx_o    (win_idx)
  );

  always_comb begin
    state_d     = state_q;
    grant_vec_d = grant_vec_q;
    grant_idx_d = grant_idx_q;
    ptr_d       = ptr_q;

    if (flush_i) begin
      // Flush overrides any same-cycle handshake; pointer is left alone.
      state_d     = SEL_IDLE;
      grant_vec_d = '0;
      grant_idx_d = '0;
    end else begin
      case (state_q)
        SEL_IDLE: begin
          if (|req_i) begin
            state_d     = SEL_HOLD;
            grant_vec_d = win_vec;
            grant_idx_d = win_idx;
          end
        end
        SEL_HOLD: begin
          if (grant_ready_i) begin
            ptr_d = ptr_adv;
            if (|win_vec) begin
              grant_vec_d = win_vec;
              grant_idx_d = win_idx;
            end else begin
              state_d     = SEL_IDLE;
              grant_vec_d = '0;
              grant_idx_d = '0;
            end
          end
        end
        default: begin
          state_d     = SEL_IDLE;
          grant_vec_d = '0;
          grant_idx_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= SEL_IDLE;
      grant_vec_q <= '0;
      grant_idx_q <= '0;
      ptr_q       <= '0;
    end else begin
      state_q     <= state_d;
      grant_vec_q <= grant_vec_d;
      grant_idx_q <= grant_idx_d;
      ptr_q       <= ptr_d;
    end
  end

  assign grant_valid_o = (state_q == SEL_HOLD);
  assign grant_vec_o   = grant_vec_q;
  assign grant_idx_o   = grant_idx_q;
  assign ptr_o         = ptr_q;

endmodule

// File: tb/tb_issue_rr_select.sv
// Directed bench for issue_rr_select: a 32-entry and a 6-entry instance.
module tb_issue_rr_select;

  logic        clk;
  logic        reset_n;

  logic        flush;
  logic [31:0] req;
  logic        rdy;
  logic        gvld;
  logic [31:0] gvec;
  logic [4:0]  gidx;
  logic [4:0]  ptr;

  logic        flush6;
  logic [5:0]  req6;
  logic        rdy6;
  logic        gvld6;
  logic [5:0]  gvec6;
  logic [2:0]  gidx6;
  logic [2:0]  ptr6;

  int total = 0;
  int bad   = 0;

  issue_rr_select #(.REQ_WIDTH(32), .REQ_WIDTH_LOG(5)) u_dut32 (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush),
    .req_i         (req),
    .grant_ready_i (rdy),
    .grant_valid_o (gvld),
    .grant_vec_o   (gvec),
    .grant_idx_o   (gidx),
    .ptr_o         (ptr)
  );

  issue_rr_select #(.REQ_WIDTH(6), .REQ_WIDTH_LOG(3)) u_dut6 (
    .clk           (clk),
    .reset_n       (reset_n),
    .flush_i       (flush6),
    .req_i         (req6),
    .grant_ready_i (rdy6),
    .grant_valid_o (gvld6),
    .grant_vec_o   (gvec6),
    .grant_idx_o   (gidx6),
    .ptr_o         (ptr6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    flush   = 1'b0;
    req     = '0;
    rdy     = 1'b0;
    flush6  = 1'b0;
    req6    = '0;
    rdy6    = 1'b0;

    repeat (2) step();
    check("rst_vld", {31'd0, gvld}, 32'd0);
    check("rst_vec", gvec, 32'd0);
    check("rst_idx", {27'd0, gidx}, 32'd0);
    check("rst_ptr", {27'd0, ptr}, 32'd0);
    reset_n = 1'b1;

    // Fairness: all requesting, FU always ready.
    req = 32'hFFFF_FFFF;
    rdy = 1'b1;
    step();
    check("rr_first_idx", {27'd0, gidx}, 32'd0);
    check("rr_first_vld", {31'd0, gvld}, 32'd1);
    for (int k = 1; k < 32; k++) begin
      step();
      check($sformatf("rr_idx%0d", k), {27'd0, gidx}, k);
      check($sformatf("rr_vld%0d", k), {31'd0, gvld}, 32'd1);
    end
    step();
    check("rr_wrap_idx", {27'd0, gidx}, 32'd0);
    check("rr_wrap_vec", gvec, 32'h1);
    check("rr_wrap_ptr", {27'd0, ptr}, 32'd0);

    rdy   = 1'b0;
    req   = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("flush_idle_vld", {31'd0, gvld}, 32'd0);

    // Drive the pointer to 5: grant entry 4 then accept it.
    req = 32'h10;
    step();
    check("p5_grant4", {27'd0, gidx}, 32'd4);
    req = '0;
    rdy = 1'b1;
    step();
    check("p5_ptr", {27'd0, ptr}, 32'd5);
    check("p5_idle", {31'd0, gvld}, 32'd0);
    rdy = 1'b0;

    req = 32'h30;
    step();
    check("p5_req30_idx", {27'd0, gidx}, 32'd5);
    req   = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("p5_flush_ptr", {27'd0, ptr}, 32'd5);

    req = 32'h11;
    step();
    check("p5_wrap_idx", {27'd0, gidx}, 32'd0);
    check("p5_wrap_vec", gvec, 32'h1);
    check("p5_wrap_ptr", {27'd0, ptr}, 32'd5);
    req   = '0;
    flush = 1'b1;
    step();
    flush = 1'b0;

    // Grant held while the requester drops and the FU stalls.
    req = 32'h8;
    step();
    check("hold_idx", {27'd0, gidx}, 32'd3);
    req = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("hold_vec%0d", k), gvec, 32'h8);
      check($sformatf("hold_vld%0d", k), {31'd0, gvld}, 32'd1);
    end
    rdy = 1'b1;
    step();
    check("hold_ptr", {27'd0, ptr}, 32'd4);
    check("hold_done_vld", {31'd0, gvld}, 32'd0);
    rdy = 1'b0;

    // Flush beats a same-cycle handshake.
    req = 32'h200;
    step();
    check("fl_idx9", {27'd0, gidx}, 32'd9);
    flush = 1'b1;
    rdy   = 1'b1;
    step();
    check("fl_vld", {31'd0, gvld}, 32'd0);
    check("fl_vec", gvec, 32'd0);
    check("fl_idx", {27'd0, gidx}, 32'd0);
    check("fl_ptr", {27'd0, ptr}, 32'd4);
    rdy = 1'b0;
    step();
    check("fl_idle_noreq_grant", {31'd0, gvld}, 32'd0);
    flush = 1'b0;
    req   = '0;

    // Asynchronous reset in the middle of a hold.
    req = 32'h80;
    step();
    check("ar_idx7", {27'd0, gidx}, 32'd7);
    req = '0;
    #2;
    reset_n = 1'b0;
    #1;
    check("ar_vld", {31'd0, gvld}, 32'd0);
    check("ar_vec", gvec, 32'd0);
    check("ar_idx", {27'd0, gidx}, 32'd0);
    check("ar_ptr", {27'd0, ptr}, 32'd0);
    req = 32'h1;
    @(negedge clk);
    reset_n = 1'b1;
    step();
    check("ar_after_idx", {27'd0, gidx}, 32'd0);
    check("ar_after_vld", {31'd0, gvld}, 32'd1);
    req = '0;

    // Non-power-of-two width: 0..5 then 0, pointer tracks the accepted index.
    req6 = 6'h3F;
    rdy6 = 1'b1;
    step();
    check("w6_idx0", {29'd0, gidx6}, 32'd0);
    for (int k = 1; k < 6; k++) begin
      step();
      check($sformatf("w6_idx%0d", k), {29'd0, gidx6}, k);
      check($sformatf("w6_ptr%0d", k), {29'd0, ptr6}, k);
    end
    step();
    check("w6_wrap_idx", {29'd0, gidx6}, 32'd0);
    check("w6_wrap_vec", {26'd0, gvec6}, 32'h1);
    check("w6_wrap_ptr", {29'd0, ptr6}, 32'd0);
    req6 = '0;
    rdy6 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
